// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI register-write slave.
package spi_pkg;

  localparam int SPI_MODE          = 3;
  localparam int LSB_FIRST         = 1;
  localparam int BYTES_PER_CS      = 4;
  localparam int CLKS_PER_HALF_BIT = 8;

  // Byte positions within one chip-select frame.
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int DATA_LSB = 2;
  localparam int DATA_MSB = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COMMIT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer with rise/fall detection on the synchronized level.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nRst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;

  // Shift the pin through the synchronizer and keep a delayed copy of the last stage.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      chain <= {STAGES{RST_VAL}};
      dly   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      dly   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~dly;
  assign fall = ~chain[STAGES-1] & dly;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-3 LSB-first slave: 4-byte address/data write frames into a register file,
// with a 16-bit read-back word shifted out during the data bytes.
module spi_slave_regif
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BYTES_PER_CS = 4
) (
  input  logic        clk40M,
  input  logic        nRst,
  input  logic        spi_clk,
  input  logic        sl,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] i_rd_data,
  output logic        o_wr_valid,
  output logic [15:0] o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic        o_frame_err,
  output logic        o_busy
);

  localparam int         NBITS      = BYTES_PER_CS * 8;
  localparam logic [5:0] FRAME_BITS = 6'(NBITS);
  localparam logic [5:0] CNT_SAT    = 6'(NBITS + 1);
  localparam logic [3:0] FLUSH_CYC  = 4'(SYNC_STAGES + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk40M), .nRst(nRst), .d(spi_clk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk40M), .nRst(nRst), .d(sl), .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  // Plain synchronizer for mosi, same depth as the clock/select path so data aligns with sclk_rise.
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      mosi_chain <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
    end
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  // After reset, wait for the sync chain to flush and then for sl to be seen high, so a
  // frame interrupted by reset is ignored until its select is released.
  logic [3:0] flush_cnt;
  logic       armed;
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      flush_cnt <= 4'd0;
      armed     <= 1'b0;
    end else if (flush_cnt != FLUSH_CYC) begin
      flush_cnt <= flush_cnt + 4'd1;
      armed     <= 1'b0;
    end else begin
      flush_cnt <= flush_cnt;
      armed     <= armed | cs_lvl;
    end
  end

  spi_state_t state, state_next;
  logic [5:0]       bit_cnt, bit_cnt_next;
  logic [NBITS-1:0] rx_sr, rx_next;
  logic [NBITS-1:0] tx_sr, tx_next;
  logic             first_fall, first_next;
  logic [15:0]      addr_next, data_next;
  logic             valid_next, err_next, miso_next;

  // FSM state register.
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath next values; a cs_rise in the same cycle as sclk_rise
  // still counts that bit before COMMIT looks at the count.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    rx_next      = rx_sr;
    tx_next      = tx_sr;
    first_next   = first_fall;
    addr_next    = o_wr_addr;
    data_next    = o_wr_data;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    case (state)
      IDLE: begin
        // Mode 3: clock must be at its idle-high level when select falls.
        if (cs_fall && armed && sclk_lvl) begin
          state_next   = ACTIVE;
          bit_cnt_next = 6'd0;
          tx_next      = {i_rd_data, {(NBITS-16){1'b0}}};
          first_next   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          rx_next      = {mosi_s, rx_sr[NBITS-1:1]};
          bit_cnt_next = (bit_cnt == CNT_SAT) ? CNT_SAT : bit_cnt + 6'd1;
        end else begin
          rx_next = rx_sr;
        end
        if (sclk_fall) begin
          first_next = 1'b0;
          tx_next    = first_fall ? tx_sr : {1'b0, tx_sr[NBITS-1:1]};
        end else begin
          first_next = first_fall;
        end
        if (cs_rise) begin
          state_next = COMMIT;
        end else begin
          state_next = ACTIVE;
        end
      end
      COMMIT: begin
        state_next = IDLE;
        if (bit_cnt == FRAME_BITS) begin
          addr_next  = {rx_sr[ADDR_MSB*8 +: 8], rx_sr[ADDR_LSB*8 +: 8]};
          data_next  = {rx_sr[DATA_MSB*8 +: 8], rx_sr[DATA_LSB*8 +: 8]};
          valid_next = 1'b1;
        end else if (bit_cnt != 6'd0) begin
          err_next = 1'b1;
        end else begin
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    miso_next = (state_next == ACTIVE) ? tx_next[0] : 1'b0;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      bit_cnt     <= 6'd0;
      rx_sr       <= {NBITS{1'b0}};
      tx_sr       <= {NBITS{1'b0}};
      first_fall  <= 1'b0;
      o_wr_addr   <= 16'h0000;
      o_wr_data   <= 16'h0000;
      o_wr_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt_next;
      rx_sr       <= rx_next;
      tx_sr       <= tx_next;
      first_fall  <= first_next;
      o_wr_addr   <= addr_next;
      o_wr_data   <= data_next;
      o_wr_valid  <= valid_next;
      o_frame_err <= err_next;
      o_busy      <= (state_next == ACTIVE);
      miso        <= miso_next;
      miso_oe     <= ~cs_lvl;
    end
  end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: a behavioural mode-3 LSB-first master at 8 clk40M
// cycles per half bit, with pulse counters and a log of written address/data pairs.
`timescale 1ns/1ps
module tb_spi_slave_regif;

  logic        clk40M = 1'b0;
  logic        nRst;
  logic        spi_clk, sl, mosi;
  logic        miso, miso_oe;
  logic [15:0] i_rd_data;
  logic        o_wr_valid, o_frame_err, o_busy;
  logic [15:0] o_wr_addr, o_wr_data;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;
  logic [31:0] wlog[$];

  spi_slave_regif #(.SYNC_STAGES(2), .BYTES_PER_CS(4)) dut (
    .clk40M(clk40M), .nRst(nRst), .spi_clk(spi_clk), .sl(sl), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .i_rd_data(i_rd_data),
    .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #12.5 clk40M = ~clk40M;

  // Count pulse-high cycles and log {data, addr} at each write strobe.
  always @(negedge clk40M) begin
    if (o_wr_valid) begin
      vcnt++;
      wlog.push_back({o_wr_data, o_wr_addr});
    end
    if (o_frame_err) ecnt++;
  end

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk40M);
  endtask

  task automatic cs_assert();
    sl = 1'b0;
    wait_clk(8);
  endtask

  // Shift bits tx[first .. first+n-1]; master drives on fall and samples miso just before rise.
  task automatic shift_bits(input logic [39:0] tx, input int first, input int n,
                            inout logic [39:0] rx);
    for (int i = first; i < first + n; i++) begin
      spi_clk = 1'b0;
      mosi    = tx[i];
      wait_clk(8);
      rx[i]   = miso;
      spi_clk = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic cs_release(input int hold);
    wait_clk(8);
    sl = 1'b1;
    wait_clk(hold);
  endtask

  logic [39:0] rx;
  int v0, e0;

  initial begin
    nRst = 1'b0; spi_clk = 1'b1; sl = 1'b1; mosi = 1'b0; i_rd_data = 16'h0000;
    wait_clk(5);
    chk("rst_valid", {39'd0, o_wr_valid}, 40'd0);
    chk("rst_err",   {39'd0, o_frame_err}, 40'd0);
    chk("rst_addr_data", {8'd0, o_wr_data, o_wr_addr}, 40'd0);
    chk("rst_busy_miso", {37'd0, o_busy, miso, miso_oe}, 40'd0);
    nRst = 1'b1;
    wait_clk(10);

    // Valid frame 34 12 EF BE with read-back 0x5AA5.
    i_rd_data = 16'h5AA5;
    v0 = vcnt; e0 = ecnt; rx = 40'd0;
    cs_assert();
    chk("busy_in_frame", {38'd0, o_busy, miso_oe}, 40'd3);
    shift_bits(40'h00_BEEF_1234, 0, 32, rx);
    cs_release(20);
    chk("f1_valid_cnt", 40'(vcnt - v0), 40'd1);
    chk("f1_err_cnt",   40'(ecnt - e0), 40'd0);
    chk("f1_addr", {24'd0, o_wr_addr}, 40'h1234);
    chk("f1_data", {24'd0, o_wr_data}, 40'hBEEF);
    chk("f1_readback", {8'd0, rx[31:0]}, 40'h5AA5_0000);
    chk("idle_miso", {37'd0, miso, miso_oe, o_busy}, 40'd0);

    // Short 24-bit frame.
    v0 = vcnt; e0 = ecnt;
    cs_assert();
    shift_bits(40'h00_0077_6655, 0, 24, rx);
    cs_release(20);
    chk("short_err_cnt",   40'(ecnt - e0), 40'd1);
    chk("short_valid_cnt", 40'(vcnt - v0), 40'd0);
    chk("short_hold", {8'd0, o_wr_data, o_wr_addr}, 40'h00_BEEF_1234);

    // Long 40-bit frame, then a normal frame 01 00 02 00.
    v0 = vcnt; e0 = ecnt;
    cs_assert();
    shift_bits(40'h99_8877_6655, 0, 40, rx);
    cs_release(20);
    chk("long_err_cnt",   40'(ecnt - e0), 40'd1);
    chk("long_valid_cnt", 40'(vcnt - v0), 40'd0);
    v0 = vcnt; e0 = ecnt;
    cs_assert();
    shift_bits(40'h00_0002_0001, 0, 32, rx);
    cs_release(20);
    chk("after_long_valid", 40'(vcnt - v0), 40'd1);
    chk("after_long_regs", {8'd0, o_wr_data, o_wr_addr}, 40'h00_0002_0001);

    // Back-to-back frames with sl high for only 2 cycles.
    v0 = vcnt; e0 = ecnt;
    wlog.delete();
    cs_assert();
    shift_bits(40'h00_CAFE_00A0, 0, 32, rx);
    cs_release(2);
    cs_assert();
    shift_bits(40'h00_1357_0B0B, 0, 32, rx);
    cs_release(20);
    chk("b2b_valid_cnt", 40'(vcnt - v0), 40'd2);
    chk("b2b_err_cnt",   40'(ecnt - e0), 40'd0);
    chk("b2b_log_size",  40'(wlog.size()), 40'd2);
    if (wlog.size() == 2) begin
      chk("b2b_first",  {8'd0, wlog[0]}, 40'h00_CAFE_00A0);
      chk("b2b_second", {8'd0, wlog[1]}, 40'h00_1357_0B0B);
    end

    // Reset after 12 bits, finish the frame, then a normal frame.
    v0 = vcnt; e0 = ecnt;
    cs_assert();
    shift_bits(40'h00_A5A5_1111, 0, 12, rx);
    nRst = 1'b0;
    wait_clk(1);
    chk("midrst_regs", {8'd0, o_wr_data, o_wr_addr}, 40'd0);
    chk("midrst_flags", {35'd0, o_wr_valid, o_frame_err, o_busy, miso, miso_oe}, 40'd0);
    wait_clk(2);
    nRst = 1'b1;
    shift_bits(40'h00_A5A5_1111, 12, 20, rx);
    cs_release(20);
    chk("midrst_no_valid", 40'(vcnt - v0), 40'd0);
    chk("midrst_no_err",   40'(ecnt - e0), 40'd0);
    chk("midrst_regs_after", {8'd0, o_wr_data, o_wr_addr}, 40'd0);
    v0 = vcnt; e0 = ecnt;
    cs_assert();
    shift_bits(40'h00_4321_8765, 0, 32, rx);
    cs_release(20);
    chk("post_rst_valid", 40'(vcnt - v0), 40'd1);
    chk("post_rst_regs", {8'd0, o_wr_data, o_wr_addr}, 40'h00_4321_8765);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
